// File: rtl/fb_pixel_fetcher.sv
// fb_pixel_fetcher: walks the visible raster, reads the frame buffer inside the centred window, and queues one pixel per position (FETCH_BORDER_EN adds a 0xFF frame).
// Read data lands RAM_LATENCY cycles after rd_en; issue stalls on FIFO credit, and the consumer applies backpressure by withholding pop.
module fb_pixel_fetcher #(
   parameter int FIFO_DEPTH  = 16,
   parameter int RAM_LATENCY = 1,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int ADDR_W      = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic [2:0]        zoom_level,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   input  logic              pop,
   output logic [7:0]        pixel_out,
   output logic              pixel_valid,
   output logic              underflow,
   output logic              frame_done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int XW = $clog2(H_ACTIVE);
   localparam int YW = $clog2(V_ACTIVE);
   localparam int GW = 16;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                 state;
   logic [XW-1:0]          px;
   logic [YW-1:0]          py;
   logic [2:0]             zoom;
   logic [ADDR_W-1:0]      addr_cnt;
   logic [RAM_LATENCY-1:0] vld_sr;
   logic [7:0]             mem [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          count;

   logic [GW-1:0] win_w, win_h, x0, y0, x1, y1, xg, yg, inflight;
   logic          in_win, in_border, credit_ok, issue, rd_issue, byp_issue;
   logic          ret_vld, push, pop_ok, last_pos;
   logic [7:0]    push_dat;

   always_comb begin
      win_w = GW'(40) << zoom[1:0];
      win_h = GW'(30) << zoom[1:0];
      x0    = (GW'(H_ACTIVE) - win_w) >> 1;
      y0    = (GW'(V_ACTIVE) - win_h) >> 1;
      x1    = x0 + win_w;
      y1    = y0 + win_h;
      xg    = GW'(px);
      yg    = GW'(py);
      in_win = !zoom[2] && (xg >= x0) && (xg < x1) && (yg >= y0) && (yg < y1);
`ifdef FETCH_BORDER_EN
      // +1 on the raster side keeps the x0-1 / y0-1 edges free of wraparound
      in_border = !zoom[2] && !in_win && ((xg + 1'b1) >= x0) && (xg <= x1)
                  && ((yg + 1'b1) >= y0) && (yg <= y1);
`else
      in_border = 1'b0;
`endif
   end

   // Outstanding reads: the one on the bus now plus those in the latency pipe.
   always_comb begin
      inflight = GW'(rd_en);
      for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + GW'(vld_sr[i]);
   end

   // Bypass pushes wait for an empty pipe so pixels stay in raster order.
   assign credit_ok = (GW'(count) + inflight) < GW'(FIFO_DEPTH);
   assign issue     = (state == FETCH) && credit_ok && (in_win || (inflight == '0));
   assign rd_issue  = issue && in_win;
   assign byp_issue = issue && !in_win;
   assign ret_vld   = vld_sr[RAM_LATENCY-1];
   assign push      = !frame_start && (ret_vld || byp_issue);
   assign push_dat  = ret_vld ? rd_data : (in_border ? 8'hFF : 8'h00);
   assign pop_ok    = pop && (count != '0) && !frame_start;
   assign last_pos  = (px == XW'(H_ACTIVE - 1)) && (py == YW'(V_ACTIVE - 1));

   assign pixel_valid = (count != '0);
   assign pixel_out   = pixel_valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         px         <= '0;
         py         <= '0;
         zoom       <= 3'd2;
         addr_cnt   <= '0;
         vld_sr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         underflow  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (frame_start) begin
            state     <= FETCH;
            px        <= '0;
            py        <= '0;
            zoom      <= zoom_level;
            addr_cnt  <= '0;
            vld_sr    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_en     <= 1'b0;
            underflow <= 1'b0;
         end else begin
            vld_sr[0] <= rd_en;
            for (int i = 1; i < RAM_LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
            rd_en <= rd_issue;
            if (rd_issue) begin
               rd_addr  <= addr_cnt;
               addr_cnt <= addr_cnt + 1'b1;
            end
            if (pop && (count == '0)) underflow <= 1'b1;
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop_ok)      count <= count + 1'b1;
            else if (!push && pop_ok) count <= count - 1'b1;

            case (state)
               IDLE: ;
               FETCH: begin
                  if (issue) begin
                     if (px == XW'(H_ACTIVE - 1)) begin
                        px <= '0;
                        if (last_pos) begin
                           py    <= '0;
                           state <= DRAIN;
                        end else begin
                           py <= py + 1'b1;
                        end
                     end else begin
                        px <= px + 1'b1;
                     end
                  end
               end
               DRAIN: begin
                  if ((inflight == '0) && (count == CW'(1)) && pop_ok) begin
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
